// File: rtl/sd_pkg.sv
// sd_pkg: definitions shared by the SD-card sector read and write controls.
// Both controls import the defaults below so that the recorder and the player
// agree on the sector size and on the frame/file layout.
package sd_pkg;

  localparam int SD_SECTOR_BYTES      = 512;
  localparam int SD_SECTOR_WORDS      = SD_SECTOR_BYTES / 2;  // 16-bit FIFO words
  localparam int SD_SECTORS_PER_FRAME = 8228;
  localparam int SD_FRAMES_PER_FILE   = 180;

  // Sector sequencing states shared by the read and write controls.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_START,
    ST_BUSY,
    ST_NEXT
  } sd_state_e;

endpackage

// File: rtl/sd_sync_edge.sv
// sd_sync_edge: brings a level from another clock domain into clk through a
// two-flop synchroniser. A third flop holds the previous synchronised value
// so that single-cycle rise and fall pulses can be produced.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : asynchronous input level
//   level_o    : synchronised level
//   rise_o     : one-cycle pulse on a synchronised 0->1 transition
//   fall_o     : one-cycle pulse on a synchronised 1->0 transition
module sd_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] first (metastable) stage, [1] synchronised level, [2] previous level.
  logic [2:0] sync_q;

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge value of its neighbour and the chain shifts by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/sd_wr_ctrl.sv
// sd_wr_ctrl: sequences SD-card sector writes while recording video frames.
// It waits until the write FIFO holds a full sector, starts the SD write
// engine for one sector, waits for the engine to finish and then advances
// the sector address and the sector/frame counters. A stop request is only
// honoured at a frame boundary so the card never holds a partial frame.
//   clk, rst_n        : clock, asynchronous active-low reset
//   rec_start         : pulse, starts a recording (ignored while active)
//   rec_stop          : pulse, stop at the next frame boundary
//   wr_addr_base      : first sector of the file, sampled on accepted start
//   fifo_rd_cnt       : words available in the write FIFO
//   wr_busy           : SD write engine busy level (asynchronous)
//   wr_start_en       : one-cycle start pulse to the SD write engine
//   wr_sec_addr       : sector address of the current write
//   write_sector_cnt  : sector index within the frame
//   write_frame_cnt   : frame index within the file
//   frame_write_over  : pulse after the last sector of a frame
//   file_write_over   : pulse after the last frame of the file
//   rec_active        : high while a recording is in progress
module sd_wr_ctrl
  import sd_pkg::*;
#(
  parameter int SECTORS_PER_FRAME = SD_SECTORS_PER_FRAME,
  parameter int FRAMES_PER_FILE   = SD_FRAMES_PER_FILE,
  parameter int SECTOR_WORDS      = SD_SECTOR_WORDS,
  parameter int FIFO_CNT_W        = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rec_start,
  input  logic                  rec_stop,
  input  logic [31:0]           wr_addr_base,
  input  logic [FIFO_CNT_W-1:0] fifo_rd_cnt,
  input  logic                  wr_busy,
  output logic                  wr_start_en,
  output logic [31:0]           wr_sec_addr,
  output logic [15:0]           write_sector_cnt,
  output logic [7:0]            write_frame_cnt,
  output logic                  frame_write_over,
  output logic                  file_write_over,
  output logic                  rec_active
);

  localparam logic [FIFO_CNT_W-1:0] SECTOR_WORDS_C = FIFO_CNT_W'(SECTOR_WORDS);
  localparam logic [15:0]           LAST_SECTOR    = 16'(SECTORS_PER_FRAME - 1);
  localparam logic [7:0]            LAST_FRAME     = 8'(FRAMES_PER_FILE - 1);

  sd_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] sector_q, sector_d;
  logic [7:0]  frame_q, frame_d;
  logic        start_q, start_d;
  logic        frame_over_q, frame_over_d;
  logic        file_over_q, file_over_d;
  logic        active_q, active_d;
  logic        stop_req_q, stop_req_d;

  logic busy_fall;
  logic busy_rise_unused;
  logic busy_level_unused;

  sd_sync_edge u_busy_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (wr_busy),
    .level_o(busy_level_unused),
    .rise_o (busy_rise_unused),
    .fall_o (busy_fall)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sector_d     = sector_q;
    frame_d      = frame_q;
    frame_over_d = 1'b0;
    file_over_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A rec_stop arriving together with rec_start is simply not looked at.
        if (rec_start) begin
          addr_d   = wr_addr_base;
          sector_d = '0;
          frame_d  = '0;
          state_d  = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (fifo_rd_cnt >= SECTOR_WORDS_C) state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        // No timeout: the engine is trusted to finish every sector it starts.
        if (busy_fall) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        addr_d = addr_q + 32'd1;
        if (sector_q == LAST_SECTOR) begin
          sector_d     = '0;
          frame_over_d = 1'b1;
          if (frame_q == LAST_FRAME) begin
            file_over_d = 1'b1;
            frame_d     = '0;
            state_d     = ST_IDLE;
          end else begin
            frame_d = frame_q + 8'd1;
            state_d = stop_req_q ? ST_IDLE : ST_WAIT_DATA;
          end
        end else begin
          sector_d = sector_q + 16'd1;
          state_d  = ST_WAIT_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered from the next state so the start pulse and rec_active line
    // up exactly with the START state and the non-IDLE states.
    start_d  = (state_d == ST_START);
    active_d = (state_d != ST_IDLE);

    // Entering IDLE always wins over a stop arriving in the same cycle.
    if (state_d == ST_IDLE) begin
      stop_req_d = 1'b0;
    end else if (state_q != ST_IDLE && rec_stop) begin
      stop_req_d = 1'b1;
    end else begin
      stop_req_d = stop_req_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      sector_q     <= '0;
      frame_q      <= '0;
      start_q      <= 1'b0;
      frame_over_q <= 1'b0;
      file_over_q  <= 1'b0;
      active_q     <= 1'b0;
      stop_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sector_q     <= sector_d;
      frame_q      <= frame_d;
      start_q      <= start_d;
      frame_over_q <= frame_over_d;
      file_over_q  <= file_over_d;
      active_q     <= active_d;
      stop_req_q   <= stop_req_d;
    end
  end

  assign wr_start_en      = start_q;
  assign wr_sec_addr      = addr_q;
  assign write_sector_cnt = sector_q;
  assign write_frame_cnt  = frame_q;
  assign frame_write_over = frame_over_q;
  assign file_write_over  = file_over_q;
  assign rec_active       = active_q;

endmodule

// File: tb/tb_sd_wr_ctrl.sv
// Testbench for sd_wr_ctrl with a 4-sector frame and a 2-frame file.
// Expected pulses (start with address, frame end, file end) are queued by the
// stimulus; a monitor pops and compares whenever the DUT shows a pulse.
module tb_sd_wr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rec_start;
  logic        rec_stop;
  logic [31:0] wr_addr_base;
  logic [11:0] fifo_rd_cnt;
  logic        wr_busy;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic [15:0] write_sector_cnt;
  logic [7:0]  write_frame_cnt;
  logic        frame_write_over;
  logic        file_write_over;
  logic        rec_active;

  sd_wr_ctrl #(
    .SECTORS_PER_FRAME(4),
    .FRAMES_PER_FILE  (2),
    .SECTOR_WORDS     (256),
    .FIFO_CNT_W       (12)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rec_start       (rec_start),
    .rec_stop        (rec_stop),
    .wr_addr_base    (wr_addr_base),
    .fifo_rd_cnt     (fifo_rd_cnt),
    .wr_busy         (wr_busy),
    .wr_start_en     (wr_start_en),
    .wr_sec_addr     (wr_sec_addr),
    .write_sector_cnt(write_sector_cnt),
    .write_frame_cnt (write_frame_cnt),
    .frame_write_over(frame_write_over),
    .file_write_over (file_write_over),
    .rec_active      (rec_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        frame;
    logic        file;
    logic [31:0] addr;
  } ev_t;

  ev_t sb_q[$];
  ev_t mon_ev;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_starts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_start(input logic [31:0] addr);
    sb_q.push_back('{start: 1'b1, frame: 1'b0, file: 1'b0, addr: addr});
  endtask

  task automatic push_frame(input logic last_of_file);
    sb_q.push_back('{start: 1'b0, frame: 1'b1, file: last_of_file, addr: 32'h0});
  endtask

  // Four sector starts at consecutive addresses followed by the frame pulse.
  task automatic push_frame_seq(input logic [31:0] base, input logic last_of_file);
    for (int i = 0; i < 4; i++) push_start(base + 32'(i));
    push_frame(last_of_file);
  endtask

  // Monitor: every visible pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (wr_start_en || frame_write_over || file_write_over)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, wr_start_en, frame_write_over, file_write_over}, 32'd0);
      end else begin
        mon_ev = sb_q.pop_front();
        check("start_pulse", {31'd0, wr_start_en}, {31'd0, mon_ev.start});
        check("frame_pulse", {31'd0, frame_write_over}, {31'd0, mon_ev.frame});
        check("file_pulse", {31'd0, file_write_over}, {31'd0, mon_ev.file});
        if (mon_ev.start) check("sector_addr", wr_sec_addr, mon_ev.addr);
      end
      if (wr_start_en) n_starts++;
    end
  end

  // SD engine model: busy for 10 cycles after every start pulse.
  initial begin
    wr_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_start_en) begin
        wr_busy = 1'b1;
        repeat (10) @(negedge clk);
        wr_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_rec(input logic [31:0] base);
    @(negedge clk);
    rec_start    = 1'b1;
    wr_addr_base = base;
    @(negedge clk);
    rec_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    rec_stop = 1'b1;
    @(negedge clk);
    rec_stop = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (rec_active && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'd0, rec_active}, 32'd0);
  endtask

  task automatic wait_starts(input int n);
    int i = 0;
    while (n_starts < n && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("start_seen", {31'd0, (n_starts >= n)}, 32'd1);
  endtask

  task automatic wait_sector(input logic [15:0] idx);
    int i = 0;
    while (write_sector_cnt != idx && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("sector_reached", {16'd0, write_sector_cnt}, {16'd0, idx});
  endtask

  task automatic check_end(input string name, input logic [31:0] addr,
                           input logic [7:0] frame);
    check({name, "_addr"}, wr_sec_addr, addr);
    check({name, "_sector"}, {16'd0, write_sector_cnt}, 32'd0);
    check({name, "_frame"}, {24'd0, write_frame_cnt}, {24'd0, frame});
  endtask

  initial begin
    int s0;
    rst_n        = 1'b0;
    rec_start    = 1'b0;
    rec_stop     = 1'b0;
    wr_addr_base = 32'h0;
    fifo_rd_cnt  = 12'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_start_en", {31'd0, wr_start_en}, 32'd0);
    check("rst_rec_active", {31'd0, rec_active}, 32'd0);
    check("rst_frame_over", {31'd0, frame_write_over}, 32'd0);
    check("rst_file_over", {31'd0, file_write_over}, 32'd0);
    check_end("rst", 32'h0, 8'd0);

    // 1. Basic recording: 2 frames of 4 sectors from 0x1000
    fifo_rd_cnt = 12'd300;
    push_frame_seq(32'h0000_1000, 1'b0);
    push_frame_seq(32'h0000_1004, 1'b1);
    start_rec(32'h0000_1000);
    check("rec_active_set", {31'd0, rec_active}, 32'd1);
    wait_starts(1);
    repeat (8) @(negedge clk);
    // The engine is still busy: nothing may have advanced yet.
    check("busy_hold_sector", {16'd0, write_sector_cnt}, 32'd0);
    check("busy_hold_addr", wr_sec_addr, 32'h0000_1000);
    wait_idle("basic_idle");
    check_end("basic", 32'h0000_1008, 8'd0);
    check("basic_starts", n_starts, 32'd8);

    // 2. FIFO threshold: 255 words never starts, 256 starts one cycle later
    fifo_rd_cnt = 12'd255;
    push_frame_seq(32'h0000_0500, 1'b0);
    start_rec(32'h0000_0500);
    pulse_stop();
    s0 = n_starts;
    repeat (20) @(negedge clk);
    check("no_start_below_thr", n_starts - s0, 32'd0);
    fifo_rd_cnt = 12'd256;
    @(negedge clk);
    check("thr_start_pulse", {31'd0, wr_start_en}, 32'd1);
    @(negedge clk);
    check("thr_start_single", {31'd0, wr_start_en}, 32'd0);
    wait_idle("thr_idle");
    check_end("thr", 32'h0000_0504, 8'd1);
    fifo_rd_cnt = 12'd300;

    // 3. Stop during sector 1 of frame 0: the frame still completes
    push_frame_seq(32'h0000_3000, 1'b0);
    start_rec(32'h0000_3000);
    wait_sector(16'd1);
    pulse_stop();
    wait_idle("stop_idle");
    check_end("stop", 32'h0000_3004, 8'd1);

    // 4. Reset while the engine is busy
    push_start(32'h0000_4000);
    s0 = n_starts;
    start_rec(32'h0000_4000);
    wait_starts(s0 + 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rec_active", {31'd0, rec_active}, 32'd0);
    check("arst_start_en", {31'd0, wr_start_en}, 32'd0);
    check("arst_frame_over", {31'd0, frame_write_over}, 32'd0);
    check("arst_file_over", {31'd0, file_write_over}, 32'd0);
    check("arst_addr", wr_sec_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check_end("post_rst", 32'h0, 8'd0);
    check("post_rst_active", {31'd0, rec_active}, 32'd0);
    check("post_rst_starts", n_starts - s0, 32'd1);

    // 5a. rec_start while active and a new base are both ignored
    push_frame_seq(32'h0000_6000, 1'b0);
    push_frame_seq(32'h0000_6004, 1'b1);
    start_rec(32'h0000_6000);
    repeat (5) @(negedge clk);
    start_rec(32'h0000_2000);
    wait_idle("ignore_idle");
    check_end("ignore", 32'h0000_6008, 8'd0);

    // 5b. Simultaneous start and stop in IDLE: full file is recorded
    push_frame_seq(32'h0000_7000, 1'b0);
    push_frame_seq(32'h0000_7004, 1'b1);
    @(negedge clk);
    rec_start    = 1'b1;
    rec_stop     = 1'b1;
    wr_addr_base = 32'h0000_7000;
    @(negedge clk);
    rec_start = 1'b0;
    rec_stop  = 1'b0;
    wait_idle("startstop_idle");
    check_end("startstop", 32'h0000_7008, 8'd0);

    // 6. Address wraps from 0xFFFF_FFFF to 0
    push_start(32'hFFFF_FFFF);
    push_start(32'h0000_0000);
    push_start(32'h0000_0001);
    push_start(32'h0000_0002);
    push_frame(1'b0);
    start_rec(32'hFFFF_FFFF);
    pulse_stop();
    wait_idle("wrap_idle");
    check_end("wrap", 32'h0000_0003, 8'd1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
